bill_accum_ctrl: RTL and testbench

Sequencing controller for the 13-bit bill adder. Accepts line items (unit price, quantity) over a valid/ready handshake and builds the running bill total in a 13-bit register. It drives one internal instance of adder_13bit (13-bit a, 12-bit b, 13-bit sum, no carry-out) with repeated additions, one per quantity unit. On request it presents the final amount with a one-cycle valid pulse.

---
 rtl/bill_accum_ctrl.sv | 154 +++++++++++++++
 tb/tb_bill_accum_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bill_accum_ctrl.sv
// -----------------------------------------------------------------------------
// bill_accum_ctrl
//   Sequencing controller for the 13-bit bill adder. Accepts line items
//   (unit price, quantity) over a valid/ready handshake and accumulates the
//   running bill with one adder_13bit addition per quantity unit. On request
//   the final amount is presented with a one-cycle total_valid pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   clear        synchronous abort, discards the current bill
//   item_valid   item offered
//   item_ready   controller can accept an item (decoded from state)
//   item_price   12-bit unsigned unit price
//   item_qty     QTY_W-bit unsigned quantity
//   bill_end     request to finalize the bill
//   busy         high while adding (decoded from state)
//   total        13-bit running / final total (registered)
//   total_valid  one-cycle pulse, total is the final bill
//   item_count   number of nonzero-quantity items, saturating
//   overflow     sticky, total exceeded 8191 during this bill
//
// Build option:
//   BILL_SATURATE_EN  when defined, a wrapped sum clamps the total to 8191;
//                     otherwise the total wraps modulo 8192.
// -----------------------------------------------------------------------------

// 13-bit + 12-bit adder without carry-out.
module adder_13bit (
   input  logic [12:0] a,
   input  logic [11:0] b,
   output logic [12:0] sum
);
   assign sum = a + 13'(b);
endmodule

module bill_accum_ctrl #(
   parameter int unsigned QTY_W = 4,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             item_valid,
   output logic             item_ready,
   input  logic [11:0]      item_price,
   input  logic [QTY_W-1:0] item_qty,
   input  logic             bill_end,
   output logic             busy,
   output logic [12:0]      total,
   output logic             total_valid,
   output logic [CNT_W-1:0] item_count,
   output logic             overflow
);

   localparam int unsigned TOT_W   = 13;
   localparam int unsigned PRICE_W = 12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [TOT_W-1:0]   r_total;
   logic [PRICE_W-1:0] r_price;
   logic [QTY_W-1:0]   r_rem;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;
   logic               r_total_valid;

   logic [TOT_W-1:0]   w_sum;
   logic               w_wrap;
   logic [TOT_W-1:0]   w_next_total;

   adder_13bit u_adder (
      .a   (r_total),
      .b   (r_price),
      .sum (w_sum)
   );

   // b never exceeds 4095, so a smaller sum can only mean the add wrapped.
   assign w_wrap = (w_sum < r_total);

`ifdef BILL_SATURATE_EN
   assign w_next_total = w_wrap ? {TOT_W{1'b1}} : w_sum;
`else
   assign w_next_total = w_sum;
`endif

   // Controller state, accumulator and handshake bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state       <= S_IDLE;
         r_total       <= '0;
         r_price       <= '0;
         r_rem         <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_total_valid <= 1'b0;
      end else begin
         r_total_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A zero-quantity item is accepted and dropped; an item beats bill_end.
               if (item_valid) begin
                  if (item_qty != '0) begin
                     r_price <= item_price;
                     r_rem   <= item_qty;
                     if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                     end
                     r_state <= S_ADD;
                  end
               end else if (bill_end) begin
                  r_total_valid <= 1'b1;
                  r_state       <= S_DONE;
               end
            end

            S_ADD: begin
               r_total <= w_next_total;
               if (w_wrap) begin
                  r_overflow <= 1'b1;
               end
               r_rem <= r_rem - QTY_W'(1);
               if (r_rem == QTY_W'(1)) begin
                  r_state <= S_IDLE;
               end
            end

            S_DONE: begin
               r_total    <= '0;
               r_count    <= '0;
               r_overflow <= 1'b0;
               r_state    <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign item_ready  = (r_state == S_IDLE);
   assign busy        = (r_state == S_ADD);
   assign total       = r_total;
   assign total_valid = r_total_valid;
   assign item_count  = r_count;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_bill_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bill_accum_ctrl
//   Self-checking bench for bill_accum_ctrl. A bill-level reference model
//   (true integer sum of price*qty, count of nonzero-qty items) predicts the
//   total, count and overflow flag. Inputs change and outputs are sampled on
//   the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bill_accum_ctrl;

   localparam int unsigned QTY_W = 4;
   localparam int unsigned CNT_W = 6;

   logic             clk;
   logic             rst;
   logic             clear;
   logic             item_valid;
   logic             item_ready;
   logic [11:0]      item_price;
   logic [QTY_W-1:0] item_qty;
   logic             bill_end;
   logic             busy;
   logic [12:0]      total;
   logic             total_valid;
   logic [CNT_W-1:0] item_count;
   logic             overflow;

   int n_checks;
   int n_pass;

   // Reference model state for the current bill.
   int unsigned m_sum;
   int unsigned m_cnt;

   bill_accum_ctrl #(.QTY_W(QTY_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .item_valid  (item_valid),
      .item_ready  (item_ready),
      .item_price  (item_price),
      .item_qty    (item_qty),
      .bill_end    (bill_end),
      .busy        (busy),
      .total       (total),
      .total_valid (total_valid),
      .item_count  (item_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] exp_total();
`ifdef BILL_SATURATE_EN
      return (m_sum > 8191) ? 13'd8191 : 13'(m_sum);
`else
      return 13'(m_sum % 8192);
`endif
   endfunction

   function automatic logic [CNT_W-1:0] exp_count();
      return (m_cnt > 63) ? CNT_W'(63) : CNT_W'(m_cnt);
   endfunction

   function automatic logic exp_ovf();
      return (m_sum > 8191);
   endfunction

   // Offer one item in IDLE, then measure its ADD phase and the result.
   task automatic send_item(input logic [11:0] p, input logic [QTY_W-1:0] q);
      int n;
      n = 0;
      while (item_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (item_ready !== 1'b1) $display("FAIL ready_wait: item_ready=%b required 1", item_ready);
      else n_pass++;
      item_valid = 1'b1;
      item_price = p;
      item_qty   = q;
      @(negedge clk);
      item_valid = 1'b0;
      m_sum = m_sum + int'(p) * int'(q);
      if (q != '0) m_cnt = m_cnt + 1;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n !== int'(q)) $display("FAIL add_cycles: got %0d required %0d (qty)", n, q);
      else n_pass++;
      n_checks++;
      if (item_ready !== 1'b1) $display("FAIL ready_after_add: item_ready=%b required 1", item_ready);
      else n_pass++;
      n_checks++;
      if (total !== exp_total()) $display("FAIL running_total: got %0d required %0d", total, exp_total());
      else n_pass++;
      n_checks++;
      if (item_count !== exp_count()) $display("FAIL running_count: got %0d required %0d", item_count, exp_count());
      else n_pass++;
      n_checks++;
      if (overflow !== exp_ovf()) $display("FAIL running_ovf: got %b required %b", overflow, exp_ovf());
      else n_pass++;
   endtask

   // Request the final amount, check the pulse and the cleared bill after it.
   task automatic finish_bill();
      int n;
      bill_end = 1'b1;
      n = 0;
      while (total_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bill_end = 1'b0;
      n_checks++;
      if (total_valid !== 1'b1) $display("FAIL total_valid_wait: total_valid=%b required 1", total_valid);
      else n_pass++;
      n_checks++;
      if (total !== exp_total()) $display("FAIL final_total: got %0d required %0d", total, exp_total());
      else n_pass++;
      n_checks++;
      if (item_count !== exp_count()) $display("FAIL final_count: got %0d required %0d", item_count, exp_count());
      else n_pass++;
      n_checks++;
      if (overflow !== exp_ovf()) $display("FAIL final_ovf: got %b required %b", overflow, exp_ovf());
      else n_pass++;
      n_checks++;
      if (item_ready !== 1'b0) $display("FAIL ready_in_done: item_ready=%b required 0", item_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (total_valid !== 1'b0) $display("FAIL pulse_width: total_valid=%b required 0", total_valid);
      else n_pass++;
      n_checks++;
      if (total !== 13'd0 || item_count !== '0 || overflow !== 1'b0 || item_ready !== 1'b1)
         $display("FAIL post_done: total=%0d count=%0d ovf=%b ready=%b required 0 0 0 1",
                  total, item_count, overflow, item_ready);
      else n_pass++;
      m_sum = 0;
      m_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (total !== 13'd0 || item_ready !== 1'b1 || busy !== 1'b0 || total_valid !== 1'b0 ||
          overflow !== 1'b0 || item_count !== '0)
         $display("FAIL reset: total=%0d ready=%b busy=%b tv=%b ovf=%b count=%0d required 0 1 0 0 0 0",
                  total, item_ready, busy, total_valid, overflow, item_count);
      else n_pass++;
      m_sum = 0;
      m_cnt = 0;
   endtask

   task automatic test_basic();
      send_item(12'd250, 4'd3);
      send_item(12'd100, 4'd1);
      n_checks++;
      if (total !== 13'd850) $display("FAIL basic_total: got %0d required 850", total);
      else n_pass++;
      finish_bill();
   endtask

   task automatic test_zero_qty();
      send_item(12'd40, 4'd2);
      send_item(12'd999, 4'd0);
      n_checks++;
      if (total !== 13'd80 || item_count !== CNT_W'(1))
         $display("FAIL zero_qty: total=%0d count=%0d required 80 1", total, item_count);
      else n_pass++;
      finish_bill();
   endtask

   task automatic test_overflow();
      send_item(12'd4095, 4'd3);
      n_checks++;
`ifdef BILL_SATURATE_EN
      if (total !== 13'd8191 || overflow !== 1'b1)
         $display("FAIL overflow_sat: total=%0d ovf=%b required 8191 1", total, overflow);
      else n_pass++;
`else
      if (total !== 13'd4093 || overflow !== 1'b1)
         $display("FAIL overflow_wrap: total=%0d ovf=%b required 4093 1", total, overflow);
      else n_pass++;
`endif
      finish_bill();
   endtask

   task automatic test_clear();
      item_valid = 1'b1;
      item_price = 12'd10;
      item_qty   = 4'd15;
      @(negedge clk);
      item_valid = 1'b0;
      @(negedge clk);                 // second ADD cycle
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if (item_ready !== 1'b1 || busy !== 1'b0 || total !== 13'd0 || item_count !== '0)
         $display("FAIL clear: ready=%b busy=%b total=%0d count=%0d required 1 0 0 0",
                  item_ready, busy, total, item_count);
      else n_pass++;
      // Item offered together with clear must be discarded.
      item_valid = 1'b1;
      item_price = 12'd77;
      item_qty   = 4'd3;
      clear      = 1'b1;
      @(negedge clk);
      item_valid = 1'b0;
      clear      = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || item_count !== '0 || total !== 13'd0)
         $display("FAIL clear_item: busy=%b count=%0d total=%0d required 0 0 0", busy, item_count, total);
      else n_pass++;
      m_sum = 0;
      m_cnt = 0;
      finish_bill();
   endtask

   task automatic test_item_and_bill_end();
      item_valid = 1'b1;
      item_price = 12'd5;
      item_qty   = 4'd2;
      bill_end   = 1'b1;
      @(negedge clk);
      item_valid = 1'b0;
      m_sum = 10;
      m_cnt = 1;
      n_checks++;
      if (busy !== 1'b1 || total_valid !== 1'b0)
         $display("FAIL item_wins: busy=%b tv=%b required 1 0", busy, total_valid);
      else n_pass++;
      finish_bill();
   endtask

   task automatic test_ignore_in_add();
      item_valid = 1'b1;
      item_price = 12'd7;
      item_qty   = 4'd4;
      @(negedge clk);
      item_price = 12'd100;
      item_qty   = 4'd5;
      bill_end   = 1'b1;
      repeat (3) @(negedge clk);
      item_valid = 1'b0;
      bill_end   = 1'b0;
      @(negedge clk);
      m_sum = 28;
      m_cnt = 1;
      n_checks++;
      if (item_ready !== 1'b1 || total !== 13'd28 || item_count !== CNT_W'(1) || total_valid !== 1'b0)
         $display("FAIL ignore_in_add: ready=%b total=%0d count=%0d tv=%b required 1 28 1 0",
                  item_ready, total, item_count, total_valid);
      else n_pass++;
      finish_bill();
   endtask

   task automatic test_random();
      for (int b = 0; b < 6; b++) begin
         int k;
         k = $urandom_range(1, 8);
         for (int i = 0; i < k; i++) begin
            send_item(12'($urandom_range(0, 4095)), QTY_W'($urandom_range(0, 15)));
         end
         finish_bill();
      end
   endtask

   task automatic test_count_saturation();
      for (int i = 0; i < 66; i++) begin
         send_item(12'($urandom_range(0, 200)), 4'd1);
      end
      n_checks++;
      if (item_count !== CNT_W'(63)) $display("FAIL count_sat: got %0d required 63", item_count);
      else n_pass++;
      finish_bill();
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      m_sum      = 0;
      m_cnt      = 0;
      rst        = 1'b1;
      clear      = 1'b0;
      item_valid = 1'b0;
      item_price = '0;
      item_qty   = '0;
      bill_end   = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero_qty();
      test_overflow();
      test_clear();
      test_item_and_bill_end();
      test_ignore_in_add();
      test_random();
      test_count_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
